// File: rtl/t10_msg_pkg.sv
// Shared message-path definitions: occupancy state encoding and default
// buffer depth, used by both the receive and transmit buffers.
package t10_msg_pkg;

   // Buffer occupancy as seen by the control FSM
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_AVAIL = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   localparam int MSG_DEPTH_DEF = 4;

endpackage

// File: rtl/msg_rx_fifo_mem.sv
// Receive FIFO storage: one write port and an asynchronous head read.
// Pointers wrap naturally because DEPTH is a power of two.
module msg_rx_fifo_mem
   import t10_msg_pkg::*;
#(
   parameter int DEPTH = MSG_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointer advance; reset discards any buffered bytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/msg_rx_buf.sv
// Receive message buffer: FWFT FIFO between the serial receiver and the
// message consumer, with sticky overflow/error flags and an accept LED pulse.
// Optional feature: define MSG_RX_DROP_CNT_EN to add an 8-bit saturating
// drop_cnt output counting bytes dropped for overflow or receive error.
module msg_rx_buf
   import t10_msg_pkg::*;
#(
   parameter int DEPTH = MSG_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_byte,
   input  logic                     rx_valid,
   input  logic                     rx_err,
   input  logic                     msg_ack,
   input  logic                     err_clr,
   output logic [7:0]               msg_byte,
   output logic                     msg_valid,
   output logic                     green,
   output logic                     ovf,
   output logic                     err,
`ifdef MSG_RX_DROP_CNT_EN
   output logic [7:0]               drop_cnt,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   occ_state_t    state;
   logic [CW-1:0] count_nxt;
   logic [7:0]    head;
   logic          push;
   logic          pop;
   logic          drop_full;
   logic          drop_err;

   // A pop in the same cycle frees a slot, so FULL can still accept
   assign msg_valid = (state != ST_EMPTY);
   assign pop       = msg_ack && msg_valid;
   assign push      = rx_valid && !rx_err && ((state != ST_FULL) || pop);
   assign drop_full = rx_valid && !rx_err && (state == ST_FULL) && !pop;
   assign drop_err  = rx_valid && rx_err;

   assign msg_byte  = msg_valid ? head : 8'h00;

   // Next occupancy from this cycle's push/pop
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Occupancy FSM, accept pulse and sticky flags (set wins over clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
         count <= '0;
         green <= 1'b0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         count <= count_nxt;
         green <= push;
         if (count_nxt == '0)
            state <= ST_EMPTY;
         else if (count_nxt == CNT_FULL)
            state <= ST_FULL;
         else
            state <= ST_AVAIL;

         if (drop_full)    ovf <= 1'b1;
         else if (err_clr) ovf <= 1'b0;

         if (drop_err)     err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

`ifdef MSG_RX_DROP_CNT_EN
   logic dropped;
   assign dropped = drop_full || drop_err;

   // Saturating drop counter; a drop in the clearing cycle counts as one
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_cnt <= 8'h00;
      else if (err_clr)
         drop_cnt <= dropped ? 8'h01 : 8'h00;
      else if (dropped && drop_cnt != 8'hFF)
         drop_cnt <= drop_cnt + 8'h01;
   end
`endif

   msg_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rx_byte),
      .rd_en   (pop),
      .head    (head)
   );

endmodule
